// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite round-robin arbiter.
//   RESP_*     : AXI response codes driven on rresp/bresp.
//   rd_state_t : read-channel FSM states.
//   wr_state_t : write-channel FSM states.
//   idx_w()    : width of a grant index for n masters (never below 1 bit).
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker.
// Scans the request vector starting one position after the last grant and
// wrapping modulo N; the first requester found wins.
//   req     in  N      request bits
//   last    in  IDX_W  index of the most recently served master
//   gnt     out N      one-hot grant (all zero when nobody requests)
//   gnt_idx out IDX_W  index of the granted master
//   gnt_vld out 1      at least one request present
import axi_lite_pkg::*;

module rr_grant #(
    parameter int N = 2,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        // Offset N wraps back to 'last' itself, so a lone requester that was
        // also the previous winner is still served.
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last) + k) % N);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI-lite arbiter with independent round-robin read and
// write arbitration. A grant is held from the address phase until the
// response handshake; the next arbitration happens from IDLE one cycle later.
//
// Optional macro ARB_RESP_TIMEOUT_EN: a response that does not arrive within
// TIMEOUT_CYC cycles of entering R_DATA/W_RESP is answered locally with
// SLVERR, and a late slave response is later drained while the channel idles.
//
// Ports (master i uses slice [i*W +: W] of every per-master vector):
//   clk, rst                         clock, async active-high reset
//   m_ar*/m_r*                       master read address / data channels
//   m_aw*/m_w*/m_b*                  master write address / data / response
//   s_ar*/s_r*/s_aw*/s_w*/s_b*       single slave port
import axi_lite_pkg::*;

module axi_lite_rr_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    // master side
    input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
    input  logic [N_MASTERS-1:0]          m_arvalid,
    input  logic [N_MASTERS-1:0]          m_awvalid,
    input  logic [N_MASTERS-1:0]          m_wvalid,
    input  logic [N_MASTERS-1:0]          m_rready,
    input  logic [N_MASTERS-1:0]          m_bready,
    output logic [N_MASTERS-1:0]          m_arready,
    output logic [N_MASTERS-1:0]          m_awready,
    output logic [N_MASTERS-1:0]          m_wready,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic [N_MASTERS-1:0]          m_bvalid,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS*2-1:0]        m_rresp,
    output logic [N_MASTERS*2-1:0]        m_bresp,
    // slave side
    output logic [ADDR_W-1:0]             s_araddr,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    output logic                          s_arvalid,
    output logic                          s_awvalid,
    output logic                          s_wvalid,
    output logic                          s_rready,
    output logic                          s_bready,
    input  logic                          s_arready,
    input  logic                          s_awready,
    input  logic                          s_wready,
    input  logic                          s_rvalid,
    input  logic                          s_bvalid,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic [1:0]                    s_bresp
);

    localparam int IDX_W = idx_w(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
        $error("axi_lite_rr_arbiter: N_MASTERS must be in 2..8");
    end
    if ((DATA_W != 32 && DATA_W != 64) || STRB_W != DATA_W / 8) begin : g_bad_w
        $error("axi_lite_rr_arbiter: DATA_W must be 32 or 64 with STRB_W = DATA_W/8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("axi_lite_rr_arbiter: TIMEOUT_CYC must be at least 1");
    end

    // ---------------- state ----------------
    rd_state_t        rd_state, rd_next;
    logic [IDX_W-1:0] rgrant, rgrant_next;
    logic [IDX_W-1:0] rlast, rlast_next;

    wr_state_t        wr_state, wr_next;
    logic [IDX_W-1:0] wgrant, wgrant_next;
    logic [IDX_W-1:0] wlast, wlast_next;
    logic             aw_done, aw_done_next;
    logic             w_done, w_done_next;
    logic             aw_hs, w_hs;

    logic [N_MASTERS-1:0] r_rr_gnt, w_rr_gnt;
    logic [IDX_W-1:0]     r_rr_idx, w_rr_idx;
    logic                 r_rr_vld, w_rr_vld;

    // Timeout hooks: r_to/w_to flag the synthetic-SLVERR cycle, r_absorb /
    // w_absorb mark a slave response still owed after a timeout.
    logic r_to, w_to;
    logic r_absorb, w_absorb;

    rr_grant #(.N(N_MASTERS)) u_rd_rr (
        .req     (m_arvalid),
        .last    (rlast),
        .gnt     (r_rr_gnt),
        .gnt_idx (r_rr_idx),
        .gnt_vld (r_rr_vld)
    );

    rr_grant #(.N(N_MASTERS)) u_wr_rr (
        .req     (m_awvalid),
        .last    (wlast),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx),
        .gnt_vld (w_rr_vld)
    );

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rgrant   <= '0;
            rlast    <= IDX_W'(N_MASTERS - 1);
        end else begin
            rd_state <= rd_next;
            rgrant   <= rgrant_next;
            rlast    <= rlast_next;
        end
    end

    always_comb begin
        rd_next     = rd_state;
        rgrant_next = rgrant;
        rlast_next  = rlast;
        s_arvalid   = 1'b0;
        s_araddr    = '0;
        s_rready    = 1'b0;
        m_arready   = '0;
        m_rvalid    = '0;
        m_rdata     = '0;
        m_rresp     = '0;
        case (rd_state)
            R_IDLE: begin
                s_rready = r_absorb;
                if (r_rr_vld) begin
                    rgrant_next = r_rr_idx;
                    rd_next     = R_ADDR;
                end
            end
            R_ADDR: begin
                s_arvalid         = m_arvalid[rgrant];
                s_araddr          = m_araddr[int'(rgrant)*ADDR_W +: ADDR_W];
                m_arready[rgrant] = s_arready;
                if (m_arvalid[rgrant] && s_arready) begin
                    rd_next = R_DATA;
                end
            end
            R_DATA: begin
                if (r_to) begin
                    // Local error response; slave rready stays low so the late
                    // beat is left for the absorb logic.
                    m_rvalid[rgrant]                 = 1'b1;
                    m_rresp[int'(rgrant)*2 +: 2]     = RESP_SLVERR;
                    rlast_next                       = rgrant;
                    rd_next                          = R_IDLE;
                end else begin
                    s_rready                         = m_rready[rgrant];
                    m_rvalid[rgrant]                 = s_rvalid;
                    m_rdata[int'(rgrant)*DATA_W +: DATA_W] = s_rdata;
                    m_rresp[int'(rgrant)*2 +: 2]     = s_rresp;
                    if (s_rvalid && m_rready[rgrant]) begin
                        rlast_next = rgrant;
                        rd_next    = R_IDLE;
                    end
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wgrant   <= '0;
            wlast    <= IDX_W'(N_MASTERS - 1);
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            wgrant   <= wgrant_next;
            wlast    <= wlast_next;
            aw_done  <= aw_done_next;
            w_done   <= w_done_next;
        end
    end

    always_comb begin
        wr_next      = wr_state;
        wgrant_next  = wgrant;
        wlast_next   = wlast;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;
        s_awvalid    = 1'b0;
        s_awaddr     = '0;
        s_wvalid     = 1'b0;
        s_wdata      = '0;
        s_wstrb      = '0;
        s_bready     = 1'b0;
        m_awready    = '0;
        m_wready     = '0;
        m_bvalid     = '0;
        m_bresp      = '0;
        case (wr_state)
            W_IDLE: begin
                s_bready = w_absorb;
                // Only AW requests are arbitrated; a master presenting W
                // alone waits here until its address shows up.
                if (w_rr_vld) begin
                    wgrant_next  = w_rr_idx;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    wr_next      = W_XFER;
                end
            end
            W_XFER: begin
                // AW and W complete independently; each done flag masks its
                // channel so neither is issued twice.
                s_awvalid         = m_awvalid[wgrant] && !aw_done;
                s_awaddr          = m_awaddr[int'(wgrant)*ADDR_W +: ADDR_W];
                s_wvalid          = m_wvalid[wgrant] && !w_done;
                s_wdata           = m_wdata[int'(wgrant)*DATA_W +: DATA_W];
                s_wstrb           = m_wstrb[int'(wgrant)*STRB_W +: STRB_W];
                m_awready[wgrant] = s_awready && !aw_done;
                m_wready[wgrant]  = s_wready && !w_done;
                aw_hs             = m_awvalid[wgrant] && !aw_done && s_awready;
                w_hs              = m_wvalid[wgrant] && !w_done && s_wready;
                aw_done_next      = aw_done || aw_hs;
                w_done_next       = w_done || w_hs;
                if (aw_done_next && w_done_next) begin
                    wr_next = W_RESP;
                end
            end
            W_RESP: begin
                if (w_to) begin
                    m_bvalid[wgrant]             = 1'b1;
                    m_bresp[int'(wgrant)*2 +: 2] = RESP_SLVERR;
                    wlast_next                   = wgrant;
                    wr_next                      = W_IDLE;
                end else begin
                    s_bready                     = m_bready[wgrant];
                    m_bvalid[wgrant]             = s_bvalid;
                    m_bresp[int'(wgrant)*2 +: 2] = s_bresp;
                    if (s_bvalid && m_bready[wgrant]) begin
                        wlast_next = wgrant;
                        wr_next    = W_IDLE;
                    end
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // ---------------- response timeout ----------------
`ifdef ARB_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt, w_cnt;

    // Counters sit at zero outside the wait states, so each entry starts
    // from zero; they leave the state before they could wrap.
    assign r_to = (rd_state == R_DATA) && (r_cnt == CNT_W'(TIMEOUT_CYC));
    assign w_to = (wr_state == W_RESP) && (w_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            w_cnt    <= '0;
            r_absorb <= 1'b0;
            w_absorb <= 1'b0;
        end else begin
            r_cnt <= (rd_state == R_DATA) ? r_cnt + CNT_W'(1) : '0;
            w_cnt <= (wr_state == W_RESP) ? w_cnt + CNT_W'(1) : '0;
            // Drain one stale beat while idle; a new grant gives up on it so
            // a silent slave cannot block the channel.
            if (r_to) begin
                r_absorb <= 1'b1;
            end else if (rd_state == R_IDLE && (s_rvalid || r_rr_vld)) begin
                r_absorb <= 1'b0;
            end
            if (w_to) begin
                w_absorb <= 1'b1;
            end else if (wr_state == W_IDLE && (s_bvalid || w_rr_vld)) begin
                w_absorb <= 1'b0;
            end
        end
    end
`else
    assign r_to     = 1'b0;
    assign w_to     = 1'b0;
    assign r_absorb = 1'b0;
    assign w_absorb = 1'b0;
`endif

    // ---------------- protocol checks ----------------
    // A granted master must keep valid up until its handshake.
    a_ar_hold : assert property (@(posedge clk) disable iff (rst)
        (rd_state == R_ADDR && s_arvalid && !s_arready) |=> s_arvalid);
    a_aw_hold : assert property (@(posedge clk) disable iff (rst)
        (wr_state == W_XFER && s_awvalid && !s_awready) |=> s_awvalid);
    a_w_hold  : assert property (@(posedge clk) disable iff (rst)
        (wr_state == W_XFER && s_wvalid && !s_wready) |=> s_wvalid);
    a_onehot  : assert property (@(posedge clk) disable iff (rst)
        $onehot0(r_rr_gnt) && $onehot0(w_rr_gnt));

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
`timescale 1ns/1ps
module tb_axi_lite_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
    logic [N-1:0]    m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
    logic [N*DW-1:0] m_rdata;
    logic [N*2-1:0]  m_rresp, m_bresp;
    logic [AW-1:0]   s_araddr, s_awaddr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
    logic            s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp, s_bresp;

    int n_checks = 0;
    int n_errors = 0;

    axi_lite_rr_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_arvalid(m_arvalid), .m_awvalid(m_awvalid), .m_wvalid(m_wvalid),
        .m_rready(m_rready), .m_bready(m_bready),
        .m_arready(m_arready), .m_awready(m_awready), .m_wready(m_wready),
        .m_rvalid(m_rvalid), .m_bvalid(m_bvalid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_bresp(m_bresp),
        .s_araddr(s_araddr), .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_arvalid(s_arvalid), .s_awvalid(s_awvalid), .s_wvalid(s_wvalid),
        .s_rready(s_rready), .s_bready(s_bready),
        .s_arready(s_arready), .s_awready(s_awready), .s_wready(s_wready),
        .s_rvalid(s_rvalid), .s_bvalid(s_bvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_rready = '0; m_bready = '0;
        m_wdata = '0; m_wstrb = '0;
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_rvalid = 1'b0; s_bvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_bresp = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sctl"}, 128'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 128'(0));
        check({tag, "_mctl"}, 128'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 128'(0));
        check({tag, "_rdata"}, 128'(m_rdata), 128'(0));
        check({tag, "_sbus"}, 128'({s_araddr, s_awaddr, s_wdata, s_wstrb}), 128'(0));
        check({tag, "_resp"}, 128'({m_rresp, m_bresp}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        m_araddr = '0;
        m_awaddr = '0;
        for (int i = 0; i < N; i++) begin
            m_araddr[i*AW +: AW] = 32'((i + 1) * 32'h1000);
            m_awaddr[i*AW +: AW] = 32'((i + 1) * 32'h1000);
        end
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // ---- single read by master 1 ----
        @(negedge clk);
        m_arvalid[1] = 1'b1;
        m_araddr[1*AW +: AW] = 32'h8000_0010;
        #1 check("rd1_no_early_arvalid", 128'(s_arvalid), 128'(0));
        @(negedge clk);
        #1 check("rd1_arvalid", 128'(s_arvalid), 128'(1));
        check("rd1_araddr", 128'(s_araddr), 128'(32'h8000_0010));
        s_arready = 1'b1;
        #1 check("rd1_arready", 128'(m_arready), 128'(4'b0010));
        @(negedge clk);
        m_arvalid = '0; s_arready = 1'b0; m_rready[1] = 1'b1;
        #1 check("rd1_rready", 128'(s_rready), 128'(1));
        check("rd1_no_rvalid", 128'(m_rvalid), 128'(0));
        @(negedge clk);
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        #1 check("rd1_rvalid", 128'(m_rvalid), 128'(4'b0010));
        check("rd1_rdata", 128'(m_rdata), 128'(32'hDEAD_BEEF) << 32);
        check("rd1_rresp", 128'(m_rresp), 128'(0));
        @(negedge clk);
        s_rvalid = 1'b0; s_rdata = '0; m_rready = '0;
        #1 check("rd1_idle", 128'({m_rvalid, s_rready, s_arvalid}), 128'(0));

        // ---- fairness: four persistent requesters after a fresh reset ----
        @(negedge clk);
        rst = 1'b1;
        m_araddr[1*AW +: AW] = 32'h2000;
        @(negedge clk);
        rst = 1'b0;
        m_arvalid = 4'hF;
        m_rready  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1 check("rr_arvalid", 128'(s_arvalid), 128'(1));
            check("rr_order_addr", 128'(s_araddr), 128'(32'((k % 4 + 1) * 32'h1000)));
            s_arready = 1'b1;
            #1 check("rr_arready", 128'(m_arready), 128'(1) << (k % 4));
            @(negedge clk);
            s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hA000_0000 + 32'(k);
            #1 check("rr_rvalid", 128'(m_rvalid), 128'(1) << (k % 4));
            check("rr_rdata", 128'(m_rdata), 128'(32'hA000_0000 + 32'(k)) << (32 * (k % 4)));
            @(negedge clk);
            s_rvalid = 1'b0;
            if (k == 7) m_arvalid = '0;
            #1 check("rr_idle_gap", 128'(s_arvalid), 128'(0));
        end
        m_rready = '0;

        // ---- split write by master 0, master 1 queued behind it ----
        @(negedge clk);
        m_awvalid[0] = 1'b1;
        #1 check("wr_no_early_awvalid", 128'(s_awvalid), 128'(0));
        @(negedge clk);
        s_awready = 1'b1;
        m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1;
        m_wdata[1*DW +: DW] = 32'h0BAD_F00D; m_wstrb[1*SW +: SW] = 4'h3;
        #1 check("wr_awvalid", 128'(s_awvalid), 128'(1));
        check("wr_awaddr", 128'(s_awaddr), 128'(32'h1000));
        check("wr_awready", 128'(m_awready), 128'(4'b0001));
        check("wr_no_wvalid_leak", 128'(s_wvalid), 128'(0));
        @(negedge clk);
        #1 check("wr_aw_masked", 128'({s_awvalid, m_awready}), 128'(0));
        @(negedge clk);
        s_awready = 1'b0; s_wready = 1'b0;
        m_wvalid[0] = 1'b1; m_wdata[0 +: DW] = 32'hCAFE_0001; m_wstrb[0 +: SW] = 4'hF;
        #1 check("wr_wvalid", 128'(s_wvalid), 128'(1));
        check("wr_wdata", 128'(s_wdata), 128'(32'hCAFE_0001));
        check("wr_wready_stall", 128'(m_wready), 128'(0));
        @(negedge clk);
        #1 check("wr_wvalid_held", 128'({s_wvalid, m_wready}), 128'({1'b1, 4'b0000}));
        @(negedge clk);
        s_wready = 1'b1;
        #1 check("wr_wready", 128'(m_wready), 128'(4'b0001));
        check("wr_wstrb", 128'(s_wstrb), 128'(4'hF));
        @(negedge clk);
        s_wready = 1'b0; m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
        m_bready = 4'hF; s_bvalid = 1'b1; s_bresp = 2'b00;
        #1 check("wr_resp_quiet", 128'({s_awvalid, s_wvalid, m_awready}), 128'(0));
        check("wr_bready", 128'(s_bready), 128'(1));
        check("wr_bvalid", 128'(m_bvalid), 128'(4'b0001));
        check("wr_bresp", 128'(m_bresp), 128'(0));
        @(negedge clk);
        s_bvalid = 1'b0;
        #1 check("wr_idle_gap", 128'({s_awvalid, m_bvalid}), 128'(0));
        @(negedge clk);
        s_awready = 1'b1; s_wready = 1'b1;
        #1 check("wr1_awaddr", 128'(s_awaddr), 128'(32'h2000));
        check("wr1_wdata", 128'(s_wdata), 128'(32'h0BAD_F00D));
        check("wr1_readys", 128'({m_awready, m_wready}), 128'({4'b0010, 4'b0010}));
        @(negedge clk);
        s_awready = 1'b0; s_wready = 1'b0; m_awvalid = '0; m_wvalid = '0;
        s_bvalid = 1'b1; s_bresp = 2'b11;
        #1 check("wr1_direct_resp", 128'({s_awvalid, s_wvalid, m_bvalid}), 128'({2'b00, 4'b0010}));
        check("wr1_bresp", 128'(m_bresp), 128'(8'b0000_1100));
        @(negedge clk);
        s_bvalid = 1'b0; s_bresp = '0; m_bready = '0;

        // ---- concurrent read (master 0) and write (master 1) ----
        @(negedge clk);
        m_arvalid[0] = 1'b1;
        m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1;
        @(negedge clk);
        #1 check("cc_valids", 128'({s_arvalid, s_awvalid, s_wvalid}), 128'(3'b111));
        check("cc_addrs", 128'({s_araddr, s_awaddr}), 128'({32'h1000, 32'h2000}));
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        #1 check("cc_readys", 128'({m_arready, m_awready, m_wready}), 128'({4'b0001, 4'b0010, 4'b0010}));
        @(negedge clk);
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rresp = 2'b01;
        s_bvalid = 1'b1; s_bresp = 2'b10;
        m_rready = 4'hF; m_bready = 4'hF;
        #1 check("cc_resp_valids", 128'({m_rvalid, m_bvalid}), 128'({4'b0001, 4'b0010}));
        check("cc_rdata", 128'(m_rdata), 128'(32'h1234_5678));
        check("cc_resps", 128'({m_rresp, m_bresp}), 128'({8'h01, 8'h08}));
        @(negedge clk);
        s_rvalid = 1'b0; s_bvalid = 1'b0; s_rresp = '0; s_bresp = '0;
        m_rready = '0; m_bready = '0;

        // ---- reset while master 2 sits in the data phase ----
        @(negedge clk);
        m_arvalid[2] = 1'b1;
        @(negedge clk);
        s_arready = 1'b1;
        #1 check("mr_arready", 128'(m_arready), 128'(4'b0100));
        @(negedge clk);
        s_arready = 1'b0; m_arvalid = '0; m_rready = 4'hF;
        s_rvalid = 1'b1; s_rdata = 32'h55AA_55AA;
        #1 check("mr_rvalid", 128'(m_rvalid), 128'(4'b0100));
        #1 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        m_arvalid = 4'b0101;
        @(negedge clk);
        #1 check("post_rst_first", 128'(s_araddr), 128'(32'h1000));
        s_arready = 1'b1;
        #1 check("post_rst_arready", 128'(m_arready), 128'(4'b0001));
        @(negedge clk);
        s_arready = 1'b0; m_arvalid = '0; m_rready = 4'hF;
        s_rvalid = 1'b1; s_rdata = 32'h0000_0A0A;
        #1 check("post_rst_rvalid", 128'(m_rvalid), 128'(4'b0001));
        @(negedge clk);
        s_rvalid = 1'b0; s_rdata = '0; m_rready = '0;

`ifdef ARB_RESP_TIMEOUT_EN
        // ---- silent slave: local SLVERR after 16 cycles in R_DATA ----
        @(negedge clk);
        m_arvalid[3] = 1'b1;
        @(negedge clk);
        s_arready = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            s_arready = 1'b0; m_arvalid = '0;
            #1;
            if (c == 15) check("to_not_yet", 128'(m_rvalid), 128'(0));
            if (c == 16) begin
                check("to_rvalid", 128'(m_rvalid), 128'(4'b1000));
                check("to_rresp", 128'(m_rresp), 128'(8'h80));
                check("to_rdata", 128'(m_rdata), 128'(0));
            end
        end
        @(negedge clk);
        #1 check("to_idle_absorb", 128'({m_rvalid, s_rready}), 128'({4'b0000, 1'b1}));
        m_arvalid[1] = 1'b1;
        @(negedge clk);
        #1 check("to_next_read", 128'({s_arvalid, s_araddr}), 128'({1'b1, 32'h2000}));
        m_arvalid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
